// File: rtl/program_counter_fetch_if.sv
// Fetch-stage bundle: PC to/from the PC+4 adder, redirect from execute and the instruction-memory request.
// master = fetch stage; slave = surrounding core and memory.
interface program_counter_fetch_if #(
  parameter int DWIDTH = 32
);
  logic [DWIDTH-1:0] program_count_curr;
  logic [DWIDTH-1:0] program_count_next;
  logic              branch_taken;
  logic [DWIDTH-1:0] branch_target;
  logic              stall;
  logic              fetch_req_valid;
  logic              fetch_req_ready;
  logic [DWIDTH-1:0] fetch_addr;
  logic              misaligned_err;

  modport master (
    output program_count_curr,
    input  program_count_next,
    input  branch_taken,
    input  branch_target,
    input  stall,
    output fetch_req_valid,
    input  fetch_req_ready,
    output fetch_addr,
    output misaligned_err
  );

  modport slave (
    input  program_count_curr,
    output program_count_next,
    output branch_taken,
    output branch_target,
    output stall,
    input  fetch_req_valid,
    output fetch_req_ready,
    input  fetch_addr,
    input  misaligned_err
  );
endinterface

// File: rtl/program_counter_fetch.sv
// PC register and fetch-request issue; request visible in the PC's own cycle (0-cycle accept when ready is high).
// Backpressure: an unaccepted request is held with a stable address; stall only blocks new issues.
module program_counter_fetch #(
  parameter int                 DWIDTH       = 32,
  parameter logic [DWIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  program_counter_fetch_if.master pcf
);

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              out_q, out_d;
  logic              err_q, err_d;
  logic              req_vld;
  logic              accept;
  logic              misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_WAIT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      out_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    req_vld    = (state_q == FETCH) && (out_q || !pcf.stall);
    accept     = req_vld && pcf.fetch_req_ready;
    misaligned = (pcf.branch_target[1:0] != 2'b00);
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    out_d      = 1'b0;
    err_d      = err_q;

    case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH: begin
        out_d = req_vld && !pcf.fetch_req_ready;
        if (pcf.branch_taken && misaligned) begin
          err_d      = 1'b1;
          state_d    = HALT;
          pend_vld_d = 1'b0;
          out_d      = 1'b0;
        end else if (pcf.branch_taken && out_q && !accept) begin
          // Address must stay put while the request is in flight; park the target.
          pend_d     = pcf.branch_target;
          pend_vld_d = 1'b1;
        end else if (pcf.branch_taken) begin
          pc_d       = pcf.branch_target;
          pend_vld_d = 1'b0;
        end else if (accept && pend_vld_q) begin
          pc_d       = pend_q;
          pend_vld_d = 1'b0;
        end else if (accept) begin
          pc_d = pcf.program_count_next;
        end
      end
      default: ;
    endcase
  end

  assign pcf.program_count_curr = pc_q;
  assign pcf.fetch_addr         = pc_q;
  assign pcf.fetch_req_valid    = req_vld;
  assign pcf.misaligned_err     = err_q;

endmodule

// File: tb/tb_program_counter_fetch.sv
// Directed bench for program_counter_fetch: per-cycle comparison against a rule-level model plus literal spot checks.
module tb_program_counter_fetch;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  program_counter_fetch_if #(.DWIDTH(32)) pif ();

  program_counter_fetch #(
    .DWIDTH       (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pcf   (pif.master)
  );

  // External PC+4 adder.
  assign pif.program_count_next = pif.program_count_curr + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting after reset, 1 = fetching, 2 = halted.
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_err;
  logic        m_pend_vld;
  logic [31:0] m_pend_val;
  logic        m_valid;
  logic        m_acc;

  assign m_valid = (m_phase == 1) && (m_out || !pif.stall);
  assign m_acc   = m_valid && pif.fetch_req_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase    <= 0;
      m_pc       <= 32'h0;
      m_out      <= 1'b0;
      m_err      <= 1'b0;
      m_pend_vld <= 1'b0;
      m_pend_val <= 32'h0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      m_out <= m_valid && !pif.fetch_req_ready;
      if (pif.branch_taken && (pif.branch_target % 4 != 0)) begin
        m_err      <= 1'b1;
        m_phase    <= 2;
        m_pend_vld <= 1'b0;
        m_out      <= 1'b0;
      end else if (pif.branch_taken && m_out && !m_acc) begin
        m_pend_vld <= 1'b1;
        m_pend_val <= pif.branch_target;
      end else if (pif.branch_taken) begin
        m_pc       <= pif.branch_target;
        m_pend_vld <= 1'b0;
      end else if (m_acc && m_pend_vld) begin
        m_pc       <= m_pend_val;
        m_pend_vld <= 1'b0;
      end else if (m_acc) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_fetch_addr", pif.fetch_addr, m_pc);
    chk("model_pc_curr", pif.program_count_curr, m_pc);
    chk("model_valid", {31'b0, pif.fetch_req_valid}, {31'b0, m_valid});
    chk("model_err", {31'b0, pif.misaligned_err}, {31'b0, m_err});
  end

  task automatic cyc(input logic bt, input logic [31:0] tg, input logic st, input logic rd);
    @(posedge clk);
    #1;
    pif.branch_taken    = bt;
    pif.branch_target   = tg;
    pif.stall           = st;
    pif.fetch_req_ready = rd;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    pif.branch_taken    = 1'b0;
    pif.branch_target   = 32'h0;
    pif.stall           = 1'b0;
    pif.fetch_req_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_valid", {31'b0, pif.fetch_req_valid}, 32'd0);
    chk("rst_wait_addr", pif.fetch_addr, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    pif.branch_taken    = 1'b0;
    pif.branch_target   = 32'h0;
    pif.stall           = 1'b0;
    pif.fetch_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_err", {31'b0, pif.misaligned_err}, 32'd0);
    release_rst();

    // Streaming fetch
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("first_valid", {31'b0, pif.fetch_req_valid}, 32'd1);
                                  chk("first_addr", pif.fetch_addr, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("seq_addr_4", pif.fetch_addr, 32'h4);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("seq_addr_8", pif.fetch_addr, 32'h8);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("seq_addr_c", pif.fetch_addr, 32'hc);

    // Backpressure with stall pulses
    cyc(1'b0, 32'h0, 1'b0, 1'b0); chk("bp_addr_1", pif.fetch_addr, 32'h10);
    cyc(1'b0, 32'h0, 1'b1, 1'b0); chk("bp_stall_valid", {31'b0, pif.fetch_req_valid}, 32'd1);
                                  chk("bp_addr_2", pif.fetch_addr, 32'h10);
    cyc(1'b0, 32'h0, 1'b0, 1'b0); chk("bp_addr_3", pif.fetch_addr, 32'h10);
    cyc(1'b0, 32'h0, 1'b1, 1'b1); chk("bp_accept_valid", {31'b0, pif.fetch_req_valid}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("bp_after_accept", pif.fetch_addr, 32'h14);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("seq_addr_1c", pif.fetch_addr, 32'h1c);

    // Redirects while a request is outstanding
    cyc(1'b0, 32'h0,   1'b0, 1'b0); chk("out_addr_20", pif.fetch_addr, 32'h20);
    cyc(1'b1, 32'h200, 1'b0, 1'b0); chk("defer_addr_20", pif.fetch_addr, 32'h20);
    cyc(1'b0, 32'h0,   1'b0, 1'b1); chk("accept_addr_20", pif.fetch_addr, 32'h20);
    cyc(1'b0, 32'h0,   1'b0, 1'b0); chk("pending_taken", pif.fetch_addr, 32'h200);
    cyc(1'b1, 32'h280, 1'b0, 1'b0); chk("defer_addr_200a", pif.fetch_addr, 32'h200);
    cyc(1'b1, 32'h300, 1'b0, 1'b0); chk("defer_addr_200b", pif.fetch_addr, 32'h200);
    cyc(1'b0, 32'h0,   1'b0, 1'b1);

    // Redirect in the same cycle as an accept beats PC+4
    cyc(1'b1, 32'h40, 1'b0, 1'b1); chk("newest_pending", pif.fetch_addr, 32'h300);
    cyc(1'b1, 32'h80, 1'b0, 1'b1); chk("redirect_addr_40", pif.fetch_addr, 32'h40);
    cyc(1'b0, 32'h0,  1'b1, 1'b1); chk("redirect_addr_80", pif.fetch_addr, 32'h80);
                                   chk("stall_valid", {31'b0, pif.fetch_req_valid}, 32'd0);

    // Wrap-around
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1); chk("stall_hold_80", pif.fetch_addr, 32'h80);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("wrap_top", pif.fetch_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("wrap_zero", pif.fetch_addr, 32'h0);
                                  chk("wrap_no_err", {31'b0, pif.misaligned_err}, 32'd0);

    // Misaligned redirect halts
    cyc(1'b1, 32'h102, 1'b0, 1'b1); chk("pre_halt_addr", pif.fetch_addr, 32'h4);
    cyc(1'b1, 32'h400, 1'b0, 1'b1); chk("halt_err", {31'b0, pif.misaligned_err}, 32'd1);
                                    chk("halt_valid", {31'b0, pif.fetch_req_valid}, 32'd0);
                                    chk("halt_pc", pif.fetch_addr, 32'h4);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);   chk("halt_ignore_redirect", pif.fetch_addr, 32'h4);

    // Reset out of halt
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("halt_rst_err", {31'b0, pif.misaligned_err}, 32'd0);
    chk("halt_rst_pc", pif.fetch_addr, 32'h0);
    release_rst();

    // Asynchronous reset discards an outstanding request and a pending redirect
    cyc(1'b0, 32'h0,   1'b0, 1'b0); chk("post_rst_addr", pif.fetch_addr, 32'h0);
    cyc(1'b1, 32'h500, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", {31'b0, pif.fetch_req_valid}, 32'd0);
       chk("async_rst_pc", pif.fetch_addr, 32'h0);
    release_rst();
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("fresh_addr_0", pif.fetch_addr, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1); chk("pending_discarded", pif.fetch_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
